// File: rtl/demux_rr_sched.sv
// ----------------------------------------------------------------------------
// demux_rr_sched
//
// One-word buffered demultiplexer. A word accepted from the upstream port is
// held and offered on exactly one of four output lanes. The lane is picked
// at acceptance time, either from a round-robin pointer (mode=0) or from the
// sel input (mode=1). The buffer can be refilled on the same edge that
// delivers the held word, so a continuous stream runs at one word per cycle.
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   en         scheduler enable; 0 blocks new acceptance (held word still drains)
//   mode       0 = round-robin target, 1 = fixed target from sel
//   sel        fixed target lane used when mode=1
//   in_valid   upstream word present
//   in_data    upstream word
//   in_ready   block accepts in_data this cycle
//   out_ready  per-lane ready, bit k = lane k
//   out_valid  one-hot lane-valid, bit k = lane k
//   out_data   held word, common to all lanes
//   ptr        current round-robin pointer
//   cnt0..cnt3 per-lane delivered-word counters (wrap at 256)
// ----------------------------------------------------------------------------
module demux_rr_sched #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         mode,
    input  logic [1:0]   sel,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    input  logic [3:0]   out_ready,
    output logic [3:0]   out_valid,
    output logic [W-1:0] out_data,
    output logic [1:0]   ptr,
    output logic [7:0]   cnt0,
    output logic [7:0]   cnt1,
    output logic [7:0]   cnt2,
    output logic [7:0]   cnt3
);

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   data_q,  data_d;
    logic [1:0]     tgt_q,   tgt_d;
    logic [1:0]     ptr_q,   ptr_d;
    logic [7:0]     cnt_q [4];
    logic [7:0]     cnt_d [4];

    logic           xfer_out;
    logic           xfer_in;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values computed before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            tgt_q   <= 2'd0;
            ptr_q   <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= 8'd0;
            end
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            tgt_q   <= tgt_d;
            ptr_q   <= ptr_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (xfer_in)              state_d = HOLD;
            HOLD:    if (xfer_out && !xfer_in) state_d = EMPTY;
            default:                           state_d = EMPTY;
        endcase
    end

    // Datapath next values: buffer, target, pointer and counters.
    always_comb begin
        data_d = data_q;
        tgt_d  = tgt_q;
        ptr_d  = ptr_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
        end

        if (xfer_out) begin
            cnt_d[tgt_q] = cnt_q[tgt_q] + 8'd1;
            if (!mode) begin
                ptr_d = ptr_q + 2'd1;
            end
        end

        // A word accepted on the same edge as a round-robin delivery takes
        // the already-advanced pointer, so a back-to-back stream visits
        // lanes 0,1,2,3,0,... instead of repeating a lane.
        if (xfer_in) begin
            data_d = in_data;
            tgt_d  = mode ? sel : ptr_d;
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        out_valid = 4'b0000;
        if (state_q == HOLD) begin
            out_valid = 4'b0001 << tgt_q;
        end
        // Only the latched target lane's ready bit matters.
        xfer_out = (state_q == HOLD) && out_ready[tgt_q];
        in_ready = en && ((state_q == EMPTY) || xfer_out);
        xfer_in  = in_valid && in_ready;
    end

    assign out_data = data_q;
    assign ptr      = ptr_q;
    assign cnt0     = cnt_q[0];
    assign cnt1     = cnt_q[1];
    assign cnt2     = cnt_q[2];
    assign cnt3     = cnt_q[3];

endmodule

// File: tb/tb_demux_rr_sched.sv
// ----------------------------------------------------------------------------
// tb_demux_rr_sched
//
// Self-checking bench for demux_rr_sched. A transaction-level model (a queue
// holding at most one word with its target lane, a pointer and four counters)
// predicts every output each cycle; directed scenarios add explicit checks.
// ----------------------------------------------------------------------------
module tb_demux_rr_sched;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         mode;
    logic [1:0]   sel;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic [3:0]   out_ready;
    logic [3:0]   out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   ptr;
    logic [7:0]   cnt0, cnt1, cnt2, cnt3;

    int checks = 0;
    int errors = 0;

    demux_rr_sched #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .ptr       (ptr),
        .cnt0      (cnt0),
        .cnt1      (cnt1),
        .cnt2      (cnt2),
        .cnt3      (cnt3)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic [W-1:0] data;
        int           lane;
    } word_t;

    word_t        m_buf[$];
    int           m_ptr;
    int           m_cnt[4];
    logic [W-1:0] m_last;

    function automatic void model_reset();
        m_buf.delete();
        m_ptr  = 0;
        m_last = '0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endfunction

    function automatic logic [3:0] m_valid();
        logic [3:0] v;
        v = 4'b0000;
        if (m_buf.size() != 0) v[m_buf[0].lane] = 1'b1;
        return v;
    endfunction

    function automatic bit m_deliver();
        return (m_buf.size() != 0) && out_ready[m_buf[0].lane];
    endfunction

    function automatic logic m_in_ready();
        return en && ((m_buf.size() == 0) || m_deliver());
    endfunction

    function automatic logic [7:0] dut_cnt(input int k);
        case (k)
            0:       return cnt0;
            1:       return cnt1;
            2:       return cnt2;
            default: return cnt3;
        endcase
    endfunction

    // Compare all outputs against the model, advance the model by one edge,
    // then step to just after the next rising edge.
    task automatic cycle(input string tag);
        bit     dlv;
        bit     acc;
        word_t  w;
        #2;
        checks++;
        if (out_valid !== m_valid() || out_data !== m_last || in_ready !== m_in_ready()
            || ptr !== m_ptr[1:0]) begin
            errors++;
            $display("FAIL %s t=%0t: out_valid=%b out_data=%h in_ready=%b ptr=%0d, expected %b %h %b %0d",
                     tag, $time, out_valid, out_data, in_ready, ptr,
                     m_valid(), m_last, m_in_ready(), m_ptr[1:0]);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (dut_cnt(k) !== 8'(m_cnt[k])) begin
                errors++;
                $display("FAIL %s cnt%0d t=%0t: got %0d expected %0d",
                         tag, k, $time, dut_cnt(k), m_cnt[k] % 256);
            end
        end
        dlv = m_deliver();
        acc = in_valid && m_in_ready();
        if (dlv) begin
            m_cnt[m_buf[0].lane] = (m_cnt[m_buf[0].lane] + 1) % 256;
            if (!mode) m_ptr = (m_ptr + 1) % 4;
            void'(m_buf.pop_front());
        end
        if (acc) begin
            w.data = in_data;
            w.lane = mode ? int'(sel) : m_ptr;
            m_buf.push_back(w);
            m_last = in_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic expect_bits(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic idle_inputs();
        en        = 1'b1;
        mode      = 1'b0;
        sel       = 2'd0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 4'b0000;
    endtask

    // Releases reset mid-cycle and steps to the next drive point.
    task automatic release_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        #1;
        expect_bits("in_ready_after_release", 32'(in_ready), 32'(en));
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        release_reset();
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        expect_bits("reset_out_valid", 32'(out_valid), 32'h0);
        expect_bits("reset_out_data",  32'(out_data),  32'h0);
        expect_bits("reset_ptr",       32'(ptr),       32'h0);
        expect_bits("reset_cnts",      {cnt3, cnt2, cnt1, cnt0}, 32'h0);
        release_reset();
        cycle("reset_idle");
    endtask

    task automatic test_round_robin();
        apply_reset();
        out_ready = 4'hF;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hA0 + 8'(i);
            cycle("rr_stream");
            expect_bits("rr_out_valid", 32'(out_valid), 32'(4'b0001 << (i % 4)));
            expect_bits("rr_out_data",  32'(out_data),  32'(8'hA0 + 8'(i)));
        end
        in_valid = 1'b0;
        cycle("rr_drain");
        expect_bits("rr_cnts", {cnt3, cnt2, cnt1, cnt0}, {8'd1, 8'd1, 8'd1, 8'd2});
        expect_bits("rr_ptr_wrapped", 32'(ptr), 32'd1);
        expect_bits("rr_empty", 32'(out_valid), 32'h0);
    endtask

    task automatic test_backpressure();
        apply_reset();
        mode      = 1'b1;
        sel       = 2'd2;
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        out_ready = 4'b1011;
        cycle("bp_accept");
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            expect_bits("bp_hold_valid",    32'(out_valid), 32'(4'b0100));
            expect_bits("bp_hold_in_ready", 32'(in_ready),  32'd0);
            cycle("bp_hold");
        end
        out_ready = 4'b0100;
        #1;
        expect_bits("bp_last_valid",    32'(out_valid), 32'(4'b0100));
        expect_bits("bp_last_in_ready", 32'(in_ready),  32'd1);
        cycle("bp_deliver");
        expect_bits("bp_cnt2", 32'(cnt2), 32'd1);
        expect_bits("bp_ptr",  32'(ptr),  32'd0);
    endtask

    task automatic test_target_latch();
        apply_reset();
        mode     = 1'b1;
        sel      = 2'd1;
        in_valid = 1'b1;
        in_data  = 8'h33;
        cycle("tl_accept");
        in_valid  = 1'b0;
        sel       = 2'd3;
        out_ready = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            expect_bits("tl_latched_lane", 32'(out_valid), 32'(4'b0010));
            cycle("tl_hold");
        end
        out_ready = 4'b1000;
        cycle("tl_wrong_lane_ready");
        expect_bits("tl_ignored_lane3", 32'(out_valid), 32'(4'b0010));
        out_ready = 4'b0010;
        cycle("tl_deliver");
        expect_bits("tl_cnt1", 32'(cnt1), 32'd1);
        expect_bits("tl_cnt3", 32'(cnt3), 32'd0);
    endtask

    task automatic test_enable();
        apply_reset();
        mode     = 1'b1;
        sel      = 2'd0;
        in_valid = 1'b1;
        in_data  = 8'h77;
        cycle("en_accept");
        en        = 1'b0;
        in_data   = 8'h99;
        out_ready = 4'hF;
        #1;
        expect_bits("en_in_ready_low", 32'(in_ready), 32'd0);
        cycle("en_deliver");
        expect_bits("en_empty",      32'(out_valid), 32'h0);
        expect_bits("en_cnt0",       32'(cnt0),      32'd1);
        expect_bits("en_data_kept",  32'(out_data),  32'h77);
        expect_bits("en_still_low",  32'(in_ready),  32'd0);
        cycle("en_idle");
        en = 1'b1;
    endtask

    task automatic test_reset_mid_op();
        apply_reset();
        mode      = 1'b1;
        sel       = 2'd3;
        in_valid  = 1'b1;
        out_ready = 4'hF;
        for (int i = 0; i < 6; i++) begin
            in_data = 8'h10 + 8'(i);
            cycle("rm_fill");
        end
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        cycle("rm_hold");
        expect_bits("rm_pre_cnt3",  32'(cnt3),      32'd5);
        expect_bits("rm_pre_valid", 32'(out_valid), 32'(4'b1000));
        rst_n = 1'b0;
        #1;
        expect_bits("rm_valid_cleared", 32'(out_valid), 32'h0);
        expect_bits("rm_cnt3_cleared",  32'(cnt3),      32'd0);
        expect_bits("rm_ptr_cleared",   32'(ptr),       32'd0);
        expect_bits("rm_data_cleared",  32'(out_data),  32'd0);
        out_ready = 4'hF;
        release_reset();
        cycle("rm_after");
        expect_bits("rm_no_count", 32'(cnt3), 32'd0);
    endtask

    task automatic test_counter_wrap();
        apply_reset();
        mode      = 1'b1;
        sel       = 2'd0;
        out_ready = 4'hF;
        in_valid  = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_data = 8'(i);
            cycle("wrap_stream");
        end
        in_valid = 1'b0;
        cycle("wrap_drain");
        expect_bits("wrap_cnts", {cnt3, cnt2, cnt1, cnt0}, 32'h0);
        expect_bits("wrap_empty", 32'(out_valid), 32'h0);
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            en        = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            sel       = 2'($urandom_range(0, 3));
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            out_ready = 4'($urandom);
            cycle("random");
        end
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        test_reset();
        test_round_robin();
        test_backpressure();
        test_target_latch();
        test_enable();
        test_reset_mid_op();
        test_counter_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_rr_sched.md
DEMUX_RR_SCHED -- requirements
Module: demux_rr_sched

Interface
REQ-001 Parameter W, default 8: data word width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 en  input  1  scheduler enable; 0 blocks new acceptance.
REQ-005 mode  input  1  0 = round-robin target, 1 = fixed target from sel.
REQ-006 sel  input  2  fixed target lane (0..3) used when mode=1.
REQ-007 in_valid  input  1  upstream word present.
REQ-008 in_data  input  W  upstream word.
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 out_ready  input  4  per-lane ready, bit k = lane k.
REQ-011 out_valid  output  4  one-hot lane-valid, bit k = lane k.
REQ-012 out_data  output  W  held word, common to all lanes.
REQ-013 ptr  output  2  current round-robin pointer.
REQ-014 cnt0..cnt3  output  8 each  per-lane delivered-word counters.

Function
REQ-015 The block SHALL contain a one-word buffer (data, 2-bit target) and a 2-state FSM: EMPTY, HOLD.
REQ-016 Transfer in SHALL occur when in_valid & in_ready are both 1 at a rising edge.
REQ-017 Transfer out on lane k SHALL occur when out_valid[k] & out_ready[k] are both 1 at a rising edge.
REQ-018 in_ready SHALL be en & (state==EMPTY | transfer out this cycle), combinationally.
REQ-019 On transfer in, the target SHALL be latched as ptr if mode=0, or sel if mode=1.
REQ-020 Changes to mode/sel while in HOLD SHALL NOT alter the latched target.
REQ-021 In HOLD, out_valid SHALL be one-hot at the latched target; in EMPTY, out_valid SHALL be 4'b0000.
REQ-022 out_data SHALL equal the buffered word in HOLD and SHALL hold its last value in EMPTY.
REQ-023 Latency: a word accepted at edge N SHALL present on out_valid/out_data after edge N, i.e. in cycle N+1.
REQ-024 Transitions: EMPTY->HOLD on transfer in; HOLD->EMPTY on transfer out without transfer in; HOLD->HOLD with new word on simultaneous transfer out and in.
REQ-025 Simultaneous out+in SHALL sustain one word per cycle, no bubble.
REQ-026 out_ready bits of non-target lanes SHALL be ignored.
REQ-027 ptr SHALL advance by 1 modulo 4 (3 wraps to 0) on each transfer out occurring while mode=0 at that edge; unchanged otherwise.
REQ-028 On transfer out to lane k, cntk SHALL increment by 1, wrapping 255->0.
REQ-029 en=0 SHALL NOT discard a held word; it SHALL still deliver, after which state becomes EMPTY.
REQ-030 in_data/in_valid SHALL be ignored when in_ready=0.

Reset
REQ-031 rst_n low SHALL immediately force state=EMPTY, out_valid=0, out_data=0, ptr=0, cnt0..cnt3=0, independent of clk.
REQ-032 A held word SHALL be lost on reset mid-operation; no transfer out SHALL be counted for it.
REQ-033 Release of rst_n SHALL take effect at the next rising edge; in_ready SHALL equal en immediately after release.

Verification
REQ-034 Round-robin: mode=0, en=1, out_ready=4'hF, words A0,A1,A2,A3,A4 streamed back-to-back -> out_valid 0001,0010,0100,1000,0001 in consecutive cycles; ptr wraps 3->0; cnt0=2, cnt1..cnt3=1.
REQ-035 Back-pressure: mode=1, sel=2, word 5A, out_ready=4'b1011 for 3 cycles then 4'b0100 -> out_valid=0100 held 4 cycles, in_ready=0 for first 3, delivered on 4th, cnt2=1, ptr stays 0.
REQ-036 Target latch: mode=1, sel=1, word 33 accepted, then sel=3, out_ready=0 -> out_valid stays 0010 until out_ready[1]=1.
REQ-037 Enable: HOLD with word 77, en dropped to 0, target lane ready -> 77 delivered, state EMPTY, in_ready=0 while in_valid=1.
REQ-038 Reset mid-op: HOLD on lane 3, cnt3=5, assert rst_n low between edges -> out_valid=0, cnt3=0, ptr=0 immediately, without a clock edge.
REQ-039 Counter wrap: 256 deliveries to lane 0 (mode=1, sel=0) -> cnt0 returns to 0, other counters 0.
